// File: rtl/fwd_stall_ctrl.sv
// Forwarding-select and stall/flush control for the 5-stage RV32I pipeline.
// Turns ID-stage hazard codes into EX mux selects and PC/IF-ID/ID-EX controls.
module fwd_stall_ctrl #(
    parameter int LU_CYC = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             is_hazard1,
    input  logic [2:0]       hazard_reg1,
    input  logic             is_hazard2,
    input  logic [2:0]       hazard_reg2,
    input  logic             branch_taken,
    input  logic             ext_stall,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, LU_STALL, HOLD} state_t;

    state_t     st_q, st_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] mask_q, mask_d;
    logic       pend_q;
    logic [1:0] a_d, b_d;

    // {ld_b, ld_a, alu_b, alu_a}
    function automatic logic [3:0] dec(input logic v, input logic [2:0] c);
        logic [3:0] r;
        r = 4'b0000;
        if (v) begin
            case (c)
                3'd1:    r = 4'b0001;
                3'd2:    r = 4'b0010;
                3'd3:    r = 4'b0100;
                3'd4:    r = 4'b1000;
                3'd5:    r = 4'b0011;
                3'd6:    r = 4'b1100;
                default: r = 4'b0000;
            endcase
        end
        return r;
    endfunction

    logic [3:0] near, far;
    logic       near_ld, far_a, far_b;
    logic       run_like, lu_last, br_go, lu_act;

    assign near    = dec(is_hazard1, hazard_reg1);
    assign far     = dec(is_hazard2, hazard_reg2);
    assign near_ld = near[3] | near[2];
    assign far_a   = far[0] | far[2];
    assign far_b   = far[1] | far[3];

    // HOLD releasing this cycle evaluates hazards like RUN so none are lost
    assign run_like = (st_q == RUN) || (st_q == HOLD && !ext_stall);
    assign lu_last  = (st_q == LU_STALL) && (cnt_q == 2'd0);
    assign br_go    = (branch_taken | pend_q) & ~ext_stall;
    assign lu_act   = ~ext_stall &
                      ((run_like & near_ld) ||
                       (st_q == LU_STALL && cnt_q != 2'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= RUN;
            cnt_q     <= 2'd0;
            mask_q    <= 2'b00;
            pend_q    <= 1'b0;
            fwd_a_sel <= 2'b00;
            fwd_b_sel <= 2'b00;
            stall_cnt <= '0;
        end else begin
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            pend_q    <= ext_stall & (branch_taken | pend_q);
            fwd_a_sel <= a_d;
            fwd_b_sel <= b_d;
            if (pc_stall && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        mask_d = mask_q;
        if (br_go) begin
            st_d   = RUN;
            cnt_d  = 2'd0;
            mask_d = 2'b00;
        end else if (ext_stall) begin
            if (st_q == RUN)
                st_d = HOLD;
        end else begin
            unique case (st_q)
                LU_STALL: begin
                    if (cnt_q == 2'd0) begin
                        st_d   = RUN;
                        mask_d = 2'b00;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: begin
                    if (near_ld) begin
                        st_d   = LU_STALL;
                        mask_d = {near[3], near[2]};
                        cnt_d  = 2'(LU_CYC - 1);
                    end else begin
                        st_d = RUN;
                    end
                end
            endcase
        end
    end

    always_comb begin
        a_d = fwd_a_sel;
        b_d = fwd_b_sel;
        if (ext_stall) begin
            a_d = fwd_a_sel;
            b_d = fwd_b_sel;
        end else if (br_go || lu_act) begin
            a_d = 2'b00;
            b_d = 2'b00;
        end else if (lu_last) begin
            a_d = {mask_q[0], 1'b0};
            b_d = {mask_q[1], 1'b0};
        end else begin
            a_d = near[0] ? 2'b01 : (far_a ? 2'b10 : 2'b00);
            b_d = near[1] ? 2'b01 : (far_b ? 2'b10 : 2'b00);
        end
    end

    // Reset forces the combinational controls low even with ext_stall high
    always_comb begin
        pc_stall    = rst_n & ~br_go & (lu_act | ext_stall);
        if_id_stall = pc_stall;
        if_id_flush = rst_n & br_go;
        id_ex_flush = rst_n & (br_go | lu_act);
    end

endmodule

// File: tb/tb_fwd_stall_ctrl.sv
// Directed self-checking bench for fwd_stall_ctrl.
// u1: LU_CYC=1, CNT_W=16; u3: LU_CYC=3, CNT_W=2; inputs shared.
module tb_fwd_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       is_hazard1 = 1'b0, is_hazard2 = 1'b0;
    logic [2:0] hazard_reg1 = 3'd0, hazard_reg2 = 3'd0;
    logic       branch_taken = 1'b0, ext_stall = 1'b0;

    logic        pc_stall1, if_id_stall1, if_id_flush1, id_ex_flush1;
    logic [1:0]  fwd_a1, fwd_b1;
    logic [15:0] stall_cnt1;
    logic        pc_stall3, if_id_stall3, if_id_flush3, id_ex_flush3;
    logic [1:0]  fwd_a3, fwd_b3;
    logic [1:0]  stall_cnt3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fwd_stall_ctrl #(.LU_CYC(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n),
        .is_hazard1(is_hazard1), .hazard_reg1(hazard_reg1),
        .is_hazard2(is_hazard2), .hazard_reg2(hazard_reg2),
        .branch_taken(branch_taken), .ext_stall(ext_stall),
        .pc_stall(pc_stall1), .if_id_stall(if_id_stall1),
        .if_id_flush(if_id_flush1), .id_ex_flush(id_ex_flush1),
        .fwd_a_sel(fwd_a1), .fwd_b_sel(fwd_b1), .stall_cnt(stall_cnt1)
    );

    fwd_stall_ctrl #(.LU_CYC(3), .CNT_W(2)) u3 (
        .clk(clk), .rst_n(rst_n),
        .is_hazard1(is_hazard1), .hazard_reg1(hazard_reg1),
        .is_hazard2(is_hazard2), .hazard_reg2(hazard_reg2),
        .branch_taken(branch_taken), .ext_stall(ext_stall),
        .pc_stall(pc_stall3), .if_id_stall(if_id_stall3),
        .if_id_flush(if_id_flush3), .id_ex_flush(id_ex_flush3),
        .fwd_a_sel(fwd_a3), .fwd_b_sel(fwd_b3), .stall_cnt(stall_cnt3)
    );

    task automatic drv(input logic h1, input logic [2:0] c1,
                       input logic h2, input logic [2:0] c2,
                       input logic br, input logic ext);
        is_hazard1   = h1;
        hazard_reg1  = c1;
        is_hazard2   = h2;
        hazard_reg2  = c2;
        branch_taken = br;
        ext_stall    = ext;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_do();
        drv(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        drv(1, 3, 1, 5, 0, 1);
        rst_n = 1'b0;
        #3;
        checks++;
        if (pc_stall1 !== 1'b0 || if_id_stall1 !== 1'b0) begin
            errors++;
            $display("FAIL rst_stall: got %b%b want 00", pc_stall1, if_id_stall1);
        end
        checks++;
        if (if_id_flush1 !== 1'b0 || id_ex_flush1 !== 1'b0) begin
            errors++;
            $display("FAIL rst_flush: got %b%b want 00", if_id_flush1, id_ex_flush1);
        end
        checks++;
        if (fwd_a1 !== 2'b00 || fwd_b1 !== 2'b00 || stall_cnt1 !== 16'd0) begin
            errors++;
            $display("FAIL rst_regs: got %b %b %0d want 00 00 0", fwd_a1, fwd_b1, stall_cnt1);
        end
        drv(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_near_alu();
        rst_do();
        drv(1, 1, 0, 0, 0, 0);
        #1;
        checks++;
        if (pc_stall1 !== 1'b0 || id_ex_flush1 !== 1'b0) begin
            errors++;
            $display("FAIL alu_nostall: got %b%b want 00", pc_stall1, id_ex_flush1);
        end
        tick();
        checks++;
        if (fwd_a1 !== 2'b01 || fwd_b1 !== 2'b00) begin
            errors++;
            $display("FAIL alu_sel: got %b %b want 01 00", fwd_a1, fwd_b1);
        end
        drv(0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (fwd_a1 !== 2'b00) begin
            errors++;
            $display("FAIL alu_clear: got %b want 00", fwd_a1);
        end
    endtask

    task automatic test_load_use();
        rst_do();
        drv(1, 4, 0, 0, 0, 0);
        #1;
        checks++;
        if (pc_stall1 !== 1'b1 || if_id_stall1 !== 1'b1 || id_ex_flush1 !== 1'b1
            || if_id_flush1 !== 1'b0) begin
            errors++;
            $display("FAIL lu_ctrl: got %b%b%b%b want 1110",
                     pc_stall1, if_id_stall1, id_ex_flush1, if_id_flush1);
        end
        tick();
        drv(1, 1, 0, 0, 0, 0);
        #1;
        checks++;
        if (pc_stall1 !== 1'b0 || id_ex_flush1 !== 1'b0 || fwd_b1 !== 2'b00) begin
            errors++;
            $display("FAIL lu_release: got %b%b %b want 00 00",
                     pc_stall1, id_ex_flush1, fwd_b1);
        end
        tick();
        checks++;
        if (fwd_a1 !== 2'b00 || fwd_b1 !== 2'b10 || stall_cnt1 !== 16'd1) begin
            errors++;
            $display("FAIL lu_fwd: got %b %b %0d want 00 10 1", fwd_a1, fwd_b1, stall_cnt1);
        end
    endtask

    task automatic test_near_far();
        rst_do();
        drv(1, 1, 1, 5, 0, 0);
        tick();
        checks++;
        if (fwd_a1 !== 2'b01 || fwd_b1 !== 2'b10) begin
            errors++;
            $display("FAIL near_beats_far: got %b %b want 01 10", fwd_a1, fwd_b1);
        end
        drv(0, 3, 1, 6, 0, 0);
        #1;
        checks++;
        if (pc_stall1 !== 1'b0) begin
            errors++;
            $display("FAIL masked_near: got %b want 0", pc_stall1);
        end
        tick();
        checks++;
        if (fwd_a1 !== 2'b10 || fwd_b1 !== 2'b10) begin
            errors++;
            $display("FAIL far_load: got %b %b want 10 10", fwd_a1, fwd_b1);
        end
        drv(1, 7, 1, 2, 0, 0);
        tick();
        checks++;
        if (fwd_a1 !== 2'b00 || fwd_b1 !== 2'b10) begin
            errors++;
            $display("FAIL code7: got %b %b want 00 10", fwd_a1, fwd_b1);
        end
    endtask

    task automatic test_branch_cancel();
        rst_do();
        drv(1, 3, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 0, 1, 0);
        #1;
        checks++;
        if (if_id_flush3 !== 1'b1 || id_ex_flush3 !== 1'b1 || pc_stall3 !== 1'b0
            || if_id_stall3 !== 1'b0) begin
            errors++;
            $display("FAIL br_ctrl: got %b%b%b%b want 1100",
                     if_id_flush3, id_ex_flush3, pc_stall3, if_id_stall3);
        end
        tick();
        drv(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (pc_stall3 !== 1'b0 || fwd_a3 !== 2'b00 || if_id_flush3 !== 1'b0) begin
            errors++;
            $display("FAIL br_run: got %b %b %b want 0 00 0", pc_stall3, fwd_a3, if_id_flush3);
        end
        tick();
        tick();
        checks++;
        if (fwd_a3 !== 2'b00 || stall_cnt3 !== 2'd1) begin
            errors++;
            $display("FAIL br_cancel: got %b %0d want 00 1", fwd_a3, stall_cnt3);
        end
    endtask

    task automatic test_ext_in_lu();
        rst_do();
        drv(1, 4, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (pc_stall3 !== 1'b1 || id_ex_flush3 !== 1'b0 || fwd_b1 !== 2'b00) begin
                errors++;
                $display("FAIL ext_lu_%0d: got %b %b %b want 1 0 00",
                         i, pc_stall3, id_ex_flush3, fwd_b1);
            end
            tick();
        end
        drv(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (pc_stall1 !== 1'b0 || pc_stall3 !== 1'b1) begin
            errors++;
            $display("FAIL ext_resume: got %b %b want 0 1", pc_stall1, pc_stall3);
        end
        tick();
        checks++;
        if (fwd_b1 !== 2'b10 || stall_cnt1 !== 16'd5 || pc_stall3 !== 1'b1) begin
            errors++;
            $display("FAIL ext_u1: got %b %0d %b want 10 5 1", fwd_b1, stall_cnt1, pc_stall3);
        end
        tick();
        checks++;
        if (pc_stall3 !== 1'b0 || fwd_b3 !== 2'b00) begin
            errors++;
            $display("FAIL ext_u3_last: got %b %b want 0 00", pc_stall3, fwd_b3);
        end
        tick();
        checks++;
        if (fwd_b3 !== 2'b10 || stall_cnt3 !== 2'd3) begin
            errors++;
            $display("FAIL ext_u3_fwd: got %b %0d want 10 3", fwd_b3, stall_cnt3);
        end
    endtask

    task automatic test_ext_hold();
        rst_do();
        drv(1, 1, 0, 0, 0, 0);
        tick();
        drv(1, 2, 0, 0, 0, 1);
        #1;
        checks++;
        if (pc_stall1 !== 1'b1 || id_ex_flush1 !== 1'b0) begin
            errors++;
            $display("FAIL hold_ctrl: got %b %b want 1 0", pc_stall1, id_ex_flush1);
        end
        tick();
        tick();
        checks++;
        if (fwd_a1 !== 2'b01 || fwd_b1 !== 2'b00) begin
            errors++;
            $display("FAIL hold_frozen: got %b %b want 01 00", fwd_a1, fwd_b1);
        end
        drv(1, 2, 0, 0, 0, 0);
        #1;
        checks++;
        if (pc_stall1 !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: got %b want 0", pc_stall1);
        end
        tick();
        checks++;
        if (fwd_a1 !== 2'b00 || fwd_b1 !== 2'b01) begin
            errors++;
            $display("FAIL hold_resume: got %b %b want 00 01", fwd_a1, fwd_b1);
        end
    endtask

    task automatic test_branch_pending();
        rst_do();
        drv(0, 0, 0, 0, 1, 1);
        #1;
        checks++;
        if (if_id_flush1 !== 1'b0 || id_ex_flush1 !== 1'b0 || pc_stall1 !== 1'b1) begin
            errors++;
            $display("FAIL pend_wait: got %b%b%b want 001", if_id_flush1, id_ex_flush1, pc_stall1);
        end
        tick();
        drv(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (if_id_flush1 !== 1'b1 || id_ex_flush1 !== 1'b1 || pc_stall1 !== 1'b0) begin
            errors++;
            $display("FAIL pend_issue: got %b%b%b want 110", if_id_flush1, id_ex_flush1, pc_stall1);
        end
        tick();
        checks++;
        if (if_id_flush1 !== 1'b0) begin
            errors++;
            $display("FAIL pend_clear: got %b want 0", if_id_flush1);
        end
    endtask

    task automatic test_saturate_reset();
        rst_do();
        drv(1, 3, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (stall_cnt3 !== 2'd2 || pc_stall3 !== 1'b1) begin
            errors++;
            $display("FAIL mid_lu: got %0d %b want 2 1", stall_cnt3, pc_stall3);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc_stall3 !== 1'b0 || id_ex_flush3 !== 1'b0 || stall_cnt3 !== 2'd0) begin
            errors++;
            $display("FAIL mid_rst: got %b %b %0d want 0 0 0", pc_stall3, id_ex_flush3, stall_cnt3);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (pc_stall3 !== 1'b0) begin
            errors++;
            $display("FAIL post_rst: got %b want 0", pc_stall3);
        end
        drv(0, 0, 0, 0, 0, 1);
        repeat (5) tick();
        checks++;
        if (stall_cnt3 !== 2'd3 || stall_cnt1 !== 16'd5) begin
            errors++;
            $display("FAIL saturate: got %0d %0d want 3 5", stall_cnt3, stall_cnt1);
        end
        drv(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_near_alu();
        test_load_use();
        test_near_far();
        test_branch_cancel();
        test_ext_in_lu();
        test_ext_hold();
        test_branch_pending();
        test_saturate_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
